prime_even_classifier: RTL

PRIME_EVEN_CLASSIFIER -- requirements
Module: prime_even_classifier

---
 rtl/prime_even_pkg.sv | 19 +
 rtl/mod_serial.sv | 72 +++++++
 rtl/prime_even_classifier.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/prime_even_pkg.sv
// Shared types and parameter limits for the prime/even classifier.
// Statistics counters exist only when CLASSIFIER_STATS_EN is defined.
package prime_even_pkg;

  localparam int unsigned WidthDefault = 8;
  localparam int unsigned WidthMin     = 2;
  localparam int unsigned WidthMax     = 16;
  localparam int unsigned CntWDefault  = 16;
  localparam int unsigned CntWMin      = 2;
  localparam int unsigned CntWMax      = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StDiv,
    StDone
  } state_e;

endpackage

// File: rtl/mod_serial.sv
// Restoring shift-subtract remainder: WIDTH cycles per operation.
// The first quotient bit is resolved on the start edge itself.
module mod_serial
  import prime_even_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] rem
);

  localparam int unsigned CntBits = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   rem_q, sh_q, dv_q;
  logic [CntBits-1:0] cnt_q;
  logic               busy_q, done_q;

  logic [WIDTH-1:0] rem_src, dv_src, rem_step;
  logic             bit_src;
  logic [WIDTH:0]   trial;

  always_comb begin
    rem_src = rem_q;
    bit_src = sh_q[WIDTH-1];
    dv_src  = dv_q;
    if (start) begin
      rem_src = '0;
      bit_src = dividend[WIDTH-1];
      dv_src  = divisor;
    end
    trial    = {rem_src, bit_src};
    // Partial remainder stays below the divisor, so the low WIDTH bits suffice.
    rem_step = (trial >= {1'b0, dv_src}) ? WIDTH'(trial - {1'b0, dv_src}) : trial[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      sh_q   <= '0;
      dv_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q  <= rem_step;
        sh_q   <= {dividend[WIDTH-2:0], 1'b0};
        dv_q   <= divisor;
        cnt_q  <= CntBits'(1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_step;
        sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CntBits'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign rem  = rem_q;

endmodule

// File: rtl/prime_even_classifier.sv
// Classifies an operand as prime/even by trial division over odd divisors.
// Define CLASSIFIER_STATS_EN to build the saturating result counters.
module prime_even_classifier
  import prime_even_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             primos,
  output logic             pares,
  output logic [CNT_W-1:0] cnt_primos,
  output logic [CNT_W-1:0] cnt_pares
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d, d_q, d_d, d_inc, rem;
  logic             primos_q, primos_d, pares_q, pares_d;
  logic             start, mod_done;
  logic [2*WIDTH-1:0] d_ext, d_sq, n_ext;

  mod_serial #(
    .WIDTH(WIDTH)
  ) u_mod (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (n_q),
    .divisor  (d_d),
    .done     (mod_done),
    .rem      (rem)
  );

  assign d_inc = d_q + WIDTH'(2);
  assign d_ext = {{WIDTH{1'b0}}, d_inc};
  assign d_sq  = d_ext * d_ext;
  assign n_ext = {{WIDTH{1'b0}}, n_q};

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    d_d      = d_q;
    primos_d = primos_q;
    pares_d  = pares_q;
    start    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          n_d     = in_data;
          pares_d = ~in_data[0];
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (n_q < WIDTH'(2)) begin
          primos_d = 1'b0;
          state_d  = StDone;
        end else if (n_q == WIDTH'(2) || n_q == WIDTH'(3)) begin
          primos_d = 1'b1;
          state_d  = StDone;
        end else if (!n_q[0]) begin
          primos_d = 1'b0;
          state_d  = StDone;
        end else begin
          d_d     = WIDTH'(3);
          start   = 1'b1;
          state_d = StDiv;
        end
      end
      StDiv: begin
        if (mod_done) begin
          if (rem == '0) begin
            primos_d = 1'b0;
            state_d  = StDone;
          end else begin
            d_d = d_inc;
            if (d_sq > n_ext) begin
              primos_d = 1'b1;
              state_d  = StDone;
            end else begin
              start = 1'b1;
            end
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      n_q      <= '0;
      d_q      <= '0;
      primos_q <= 1'b0;
      pares_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      d_q      <= d_d;
      primos_q <= primos_d;
      pares_q  <= pares_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_data  = n_q;
  assign primos    = primos_q;
  assign pares     = pares_q;

`ifdef CLASSIFIER_STATS_EN
  logic             xfer;
  logic [CNT_W-1:0] cnt_primos_q, cnt_pares_q;

  assign xfer = out_valid & out_ready;

  // Clear wins over a coincident increment; both counters hold at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_primos_q <= '0;
      cnt_pares_q  <= '0;
    end else if (clr) begin
      cnt_primos_q <= '0;
      cnt_pares_q  <= '0;
    end else if (xfer) begin
      if (primos_q && !(&cnt_primos_q)) cnt_primos_q <= cnt_primos_q + 1'b1;
      if (pares_q && !(&cnt_pares_q))   cnt_pares_q  <= cnt_pares_q + 1'b1;
    end
  end

  assign cnt_primos = cnt_primos_q;
  assign cnt_pares  = cnt_pares_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign cnt_primos = '0;
  assign cnt_pares  = '0;
`endif

endmodule
